psum_accum_buf: RTL and testbench

Parametrised partial-sum accumulation buffer for the BitBlade PE array periphery. It replaces the plain per-cycle DFFQ/DFFQF psum registers with several features:
- per-channel signed accumulation with optional saturation
- a first/last framing protocol
- a DEPTH-entry output FIFO with valid/ready handshakes on both sides
- synchronous flush

It sits between the array's column adder-tree outputs and the output-activation writeback path.

---
 rtl/psum_pkg.sv | 33 +++
 rtl/psum_fifo.sv | 59 +++++
 rtl/psum_accum_buf.sv | 94 +++++++++
 tb/tb_psum_accum_buf.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared types and the width-generic signed add-with-overflow used by the psum accumulators.
package psum_pkg;

    localparam int unsigned MAX_W = 64;
    localparam int unsigned IDX_W = $clog2(MAX_W + 1);

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic             ovf;
    } add_res_t;

    // Operands arrive sign-extended from w bits (w < MAX_W); result low w bits are meaningful.
    function automatic add_res_t sat_add(input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] b,
                                         input int unsigned      w,
                                         input logic             sat);
        logic [MAX_W:0]   s;
        logic [MAX_W-1:0] pmax;
        add_res_t         r;
        s     = {a[MAX_W-1], a} + {b[MAX_W-1], b};
        pmax  = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
        r.ovf = s[IDX_W'(w)] ^ s[IDX_W'(w - 1)];
        r.sum = s[MAX_W-1:0];
        if (r.ovf && sat) begin
            r.sum = s[IDX_W'(w)] ? ~pmax : pmax;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_fifo.sv
// Pointer-with-wrap-bit FIFO holding finished partial-sum vectors; flush resets pointers only.
module psum_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DW-1:0]                wdata_i,
    output logic [DW-1:0]                rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign level_o = LW'(wr_q - rd_q);
    assign rdata_o = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is deliberately not reset or flushed; head is don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/psum_accum_buf.sv
// Per-channel signed psum accumulator with first/last framing, sticky overflow and output FIFO.
module psum_accum_buf
    import psum_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IN_W  = 20,
    parameter int unsigned CH    = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SAT   = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         FLUSH,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [CH*IN_W-1:0]           in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH*WIDTH-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf
);

    localparam logic MODE = (SAT != 0) ? MODE_SAT : MODE_WRAP;

    logic                full, empty, acc_en, push;
    logic [CH*WIDTH-1:0] push_data;
    logic [CH-1:0]       ch_ovf;
    logic                ovf_q, ovf_d;

    assign in_ready  = ~FLUSH & ~full;
    assign acc_en    = in_valid & in_ready;
    assign push      = acc_en & in_last;
    assign out_valid = ~empty;
    assign ovf       = ovf_q;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [WIDTH-1:0] acc_q, acc_d, a_op;
        add_res_t         res;
        logic             unused_hi;

        // A first beat loads by adding to zero, which can never overflow.
        always_comb begin
            a_op  = in_first ? '0 : acc_q;
            res   = sat_add(MAX_W'($signed(a_op)),
                            MAX_W'($signed(in_data[c*IN_W +: IN_W])),
                            WIDTH, MODE);
            acc_d = acc_q;
            if (FLUSH) begin
                acc_d = '0;
            end else if (acc_en) begin
                acc_d = in_last ? '0 : res.sum[WIDTH-1:0];
            end
        end

        assign push_data[c*WIDTH +: WIDTH] = res.sum[WIDTH-1:0];
        assign ch_ovf[c]                   = res.ovf;
        assign unused_hi                   = ^res.sum[MAX_W-1:WIDTH];

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) acc_q <= '0;
            else     acc_q <= acc_d;
        end
    end

    always_comb begin
        ovf_d = ovf_q | (acc_en & (|ch_ovf));
        if (FLUSH) ovf_d = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    psum_fifo #(
        .DW    (CH*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .flush_i (FLUSH),
        .push_i  (push),
        .pop_i   (out_ready),
        .wdata_i (push_data),
        .rdata_o (out_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

endmodule

// File: tb/tb_psum_accum_buf.sv
// Scoreboard bench: saturating and wrapping instances share stimulus, each checked against an integer model.
module tb_psum_accum_buf;

    localparam int unsigned CH    = 2;
    localparam int unsigned IN_W  = 4;
    localparam int unsigned WIDTH = 6;
    localparam int unsigned DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST, FLUSH, in_valid, in_first, in_last, out_ready;
    logic [7:0]  in_data;
    logic        in_ready_s, out_valid_s, ovf_s;
    logic        in_ready_w, out_valid_w, ovf_w;
    logic [11:0] out_data_s, out_data_w;
    logic [2:0]  level_s, level_w;

    always #5 CLK = ~CLK;

    psum_accum_buf #(.WIDTH(WIDTH), .IN_W(IN_W), .CH(CH), .DEPTH(DEPTH), .SAT(1)) dut_s (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_first(in_first), .in_last(in_last), .in_data(in_data), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .level(level_s), .ovf(ovf_s));

    psum_accum_buf #(.WIDTH(WIDTH), .IN_W(IN_W), .CH(CH), .DEPTH(DEPTH), .SAT(0)) dut_w (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_first(in_first), .in_last(in_last), .in_data(in_data), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .level(level_w), .ovf(ovf_w));

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] q_s[$];
    logic [11:0] q_w[$];
    int          acc_s[2];
    int          acc_w[2];
    logic        ovf_exp_s, ovf_exp_w;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pack2(input int a, input int b);
        logic [5:0] lo, hi;
        lo = 6'(a);
        hi = 6'(b);
        return {hi, lo};
    endfunction

    task automatic model_clear();
        q_s.delete();
        q_w.delete();
        for (int c = 0; c < 2; c++) begin
            acc_s[c] = 0;
            acc_w[c] = 0;
        end
        ovf_exp_s = 1'b0;
        ovf_exp_w = 1'b0;
    endtask

    task automatic model_beat(input logic first, input logic last, input int d0, input int d1);
        int d[2];
        int r_s[2];
        int r_w[2];
        int ss, sw;
        d[0] = d0;
        d[1] = d1;
        for (int c = 0; c < 2; c++) begin
            if (first) begin
                r_s[c] = d[c];
                r_w[c] = d[c];
            end else begin
                ss = acc_s[c] + d[c];
                if (ss > 31) begin ss = 31; ovf_exp_s = 1'b1; end
                else if (ss < -32) begin ss = -32; ovf_exp_s = 1'b1; end
                sw = acc_w[c] + d[c];
                if (sw > 31)       begin sw = sw - 64; ovf_exp_w = 1'b1; end
                else if (sw < -32) begin sw = sw + 64; ovf_exp_w = 1'b1; end
                r_s[c] = ss;
                r_w[c] = sw;
            end
        end
        if (last) begin
            q_s.push_back(pack2(r_s[0], r_s[1]));
            q_w.push_back(pack2(r_w[0], r_w[1]));
            for (int c = 0; c < 2; c++) begin acc_s[c] = 0; acc_w[c] = 0; end
        end else begin
            for (int c = 0; c < 2; c++) begin acc_s[c] = r_s[c]; acc_w[c] = r_w[c]; end
        end
    endtask

    // Holds the beat until accepted, then returns at the following falling edge.
    task automatic send_beat(input logic first, input logic last, input int d0, input int d1);
        int n = 0;
        logic [3:0] b0, b1;
        b0 = 4'(d0);
        b1 = 4'(d1);
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        in_data  = {b1, b0};
        #1;
        while (!in_ready_s && n < 100) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("beat_accept", 32'(in_ready_s), 32'd1);
        if (in_ready_s) model_beat(first, last, d0, d1);
        @(negedge CLK);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (out_valid_s && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("drain", 32'(out_valid_s), 32'd0);
    endtask

    initial begin : monitor
        logic [11:0] e_s, e_w;
        forever begin
            @(negedge CLK);
            #2;
            if (!RST && !FLUSH && out_valid_s && out_ready) begin
                chk("valid_match", 32'(out_valid_w), 32'd1);
                if (q_s.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e_s = q_s.pop_front();
                    e_w = q_w.pop_front();
                    chk("data_sat", 32'(out_data_s), 32'(e_s));
                    chk("data_wrap", 32'(out_data_w), 32'(e_w));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        RST = 1'b1; FLUSH = 1'b0; out_ready = 1'b0; in_data = '0;
        idle();
        model_clear();
        #12;
        chk("rst_in_ready", 32'(in_ready_s), 32'd1);
        chk("rst_out_valid", 32'(out_valid_s), 32'd0);
        chk("rst_level", 32'(level_s), 32'd0);
        chk("rst_ovf", 32'(ovf_s), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Basic three-beat frame
        send_beat(1'b1, 1'b0, 3, -4);
        send_beat(1'b0, 1'b0, 2, -4);
        send_beat(1'b0, 1'b1, -1, -4);
        idle();
        chk("basic_valid", 32'(out_valid_s), 32'd1);
        chk("basic_level", 32'(level_s), 32'd1);
        chk("basic_data", 32'(out_data_s), 32'h0D04);
        chk("basic_ovf", 32'(ovf_s), 32'(ovf_exp_s));
        out_ready = 1'b1;
        wait_empty();

        // Five beats of 7 on ch0: saturate at 31, wrap to -29
        out_ready = 1'b0;
        send_beat(1'b1, 1'b0, 7, 0);
        for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0, 7, 0);
        chk("ovf_pre", 32'(ovf_s), 32'd0);
        send_beat(1'b0, 1'b1, 7, 0);
        idle();
        chk("sat_ovf_s", 32'(ovf_s), 32'd1);
        chk("sat_ovf_w", 32'(ovf_w), 32'd1);
        chk("sat_data_s", 32'(out_data_s), 32'h001F);
        chk("sat_data_w", 32'(out_data_w), 32'h0023);
        out_ready = 1'b1;
        wait_empty();

        // Backpressure: four single-beat frames fill the FIFO
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) send_beat(1'b1, 1'b1, v, -v);
        idle();
        #1;
        chk("bp_level", 32'(level_s), 32'd4);
        chk("bp_in_ready", 32'(in_ready_s), 32'd0);
        chk("bp_out_valid", 32'(out_valid_s), 32'd1);
        out_ready = 1'b1;
        send_beat(1'b1, 1'b1, 5, -5);
        idle();
        wait_empty();

        // Simultaneous push and pop at level 2
        @(negedge CLK);
        out_ready = 1'b0;
        send_beat(1'b1, 1'b1, 6, 1);
        send_beat(1'b1, 1'b1, -7, 2);
        idle();
        #1;
        chk("simul_level_pre", 32'(level_s), 32'd2);
        out_ready = 1'b1;
        send_beat(1'b1, 1'b1, 3, 3);
        idle();
        out_ready = 1'b0;
        #1;
        chk("simul_level_s", 32'(level_s), 32'd2);
        chk("simul_level_w", 32'(level_w), 32'd2);
        out_ready = 1'b1;
        wait_empty();

        // Flush mid-frame with three entries queued
        @(negedge CLK);
        out_ready = 1'b0;
        send_beat(1'b1, 1'b1, 1, 1);
        send_beat(1'b1, 1'b1, 2, 2);
        send_beat(1'b1, 1'b1, 3, 3);
        send_beat(1'b1, 1'b0, 4, 4);
        idle();
        #1;
        chk("flush_level_pre", 32'(level_s), 32'd3);
        @(negedge CLK);
        FLUSH = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_first = 1'b0; in_last = 1'b1; in_data = 8'h77;
        #1;
        chk("flush_in_ready", 32'(in_ready_s), 32'd0);
        model_clear();
        @(negedge CLK);
        FLUSH = 1'b0; out_ready = 1'b0;
        idle();
        #1;
        chk("flush_level", 32'(level_s), 32'd0);
        chk("flush_out_valid", 32'(out_valid_s), 32'd0);
        chk("flush_ovf_s", 32'(ovf_s), 32'd0);
        chk("flush_ovf_w", 32'(ovf_w), 32'd0);
        send_beat(1'b0, 1'b1, 5, -2);
        idle();
        #1;
        chk("flush_after", 32'(out_data_s), 32'(pack2(5, -2)));
        out_ready = 1'b1;
        wait_empty();

        // Asynchronous reset mid-frame with the FIFO non-empty
        @(negedge CLK);
        out_ready = 1'b0;
        send_beat(1'b1, 1'b1, 4, 4);
        send_beat(1'b1, 1'b0, 3, 3);
        idle();
        #2;
        RST = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready_s), 32'd1);
        chk("arst_out_valid", 32'(out_valid_s), 32'd0);
        chk("arst_level", 32'(level_s), 32'd0);
        chk("arst_level_w", 32'(level_w), 32'd0);
        model_clear();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        send_beat(1'b0, 1'b1, 2, -1);
        idle();
        #1;
        chk("arst_after", 32'(out_data_s), 32'(pack2(2, -1)));
        out_ready = 1'b1;
        wait_empty();

        @(negedge CLK);
        chk("queue_empty", 32'(q_s.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
